// File: rtl/mac_unit.sv
// Signed 8x8 multiply plus 32-bit preloadable base; Result = base + prod, 2 enabled edges after X/Y or Z.
// No backpressure: en freezes every register (acc_load ignored), rst clears all state and wins over en.
module mac_unit (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic signed [7:0]  X,
  input  logic signed [7:0]  Y,
  input  logic               acc_load,
  input  logic signed [31:0] Z,
  output logic signed [31:0] Result
);

  logic signed [15:0] prod;
  logic signed [31:0] base;
  logic signed [31:0] prod_ext;

  // (-128)*(-128) = 16384 still fits in 16 signed bits, so no wrap at this stage.
  assign prod_ext = {{16{prod[15]}}, prod};

  always_ff @(posedge clk) begin
    if (rst) begin
      prod   <= '0;
      base   <= '0;
      Result <= '0;
    end else if (en) begin
      prod   <= X * Y;
      if (acc_load)
        base <= Z;
      // Uses pre-edge base and prod; never feeds Result back, so no running sum.
      Result <= base + prod_ext;
    end
  end

endmodule

// File: tb/tb_mac_unit.sv
// Directed-vector bench for mac_unit with hand-computed expected Result values.
module tb_mac_unit;

  logic               clk;
  logic               rst;
  logic               en;
  logic signed [7:0]  X;
  logic signed [7:0]  Y;
  logic               acc_load;
  logic signed [31:0] Z;
  logic signed [31:0] Result;

  int vectors = 0;
  int miscompares = 0;

  mac_unit dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .X        (X),
    .Y        (Y),
    .acc_load (acc_load),
    .Z        (Z),
    .Result   (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_result(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: Result=%0d (0x%08h) expected %0d (0x%08h)",
               tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; acc_load = 1'b0; X = 8'sd0; Y = 8'sd0; Z = 32'sd0;

    // Reset and first load
    tick();
    check_result("reset", Result, 32'd0);
    rst = 1'b0; en = 1'b1; acc_load = 1'b1; Z = 32'sd50;
    tick();
    check_result("first_edge_after_rst", Result, 32'd0);

    // Z=50, X=10, Y=3 -> 80 two edges later, then stable
    acc_load = 1'b0; X = 8'sd10; Y = 8'sd3;
    tick();
    check_result("xy_edge1", Result, 32'd50);
    tick();
    check_result("xy_edge2_80", Result, 32'd80);
    tick();
    check_result("stable_80", Result, 32'd80);

    // Reload Z=-20, then X=-5, Y=4: 80, 10, -40
    acc_load = 1'b1; Z = -32'sd20;
    tick();
    check_result("load_m20_old_base", Result, 32'd80);
    acc_load = 1'b0; X = -8'sd5; Y = 8'sd4;
    tick();
    check_result("mixed_10", Result, 32'd10);
    tick();
    check_result("settle_m40", Result, -32'sd40);
    tick();
    check_result("stable_m40", Result, -32'sd40);

    // Z=0, X=7, Y=-6 -> -42
    acc_load = 1'b1; Z = 32'sd0;
    tick();
    check_result("load0_old_base", Result, -32'sd40);
    acc_load = 1'b0; X = 8'sd7; Y = -8'sd6;
    tick();
    check_result("z0_mid", Result, -32'sd20);
    tick();
    check_result("neg_prod_m42", Result, -32'sd42);

    // Wrap: 0x7FFFFFFF + 1 -> 0x80000000
    acc_load = 1'b1; Z = 32'sh7FFF_FFFF; X = 8'sd1; Y = 8'sd1;
    tick();
    check_result("wrap_load", Result, -32'sd42);
    acc_load = 1'b0;
    tick();
    check_result("wrap_result", Result, 32'h8000_0000);

    // Extreme product (-128)*(-128) = 16384
    acc_load = 1'b1; Z = 32'sd0; X = -8'sd128; Y = -8'sd128;
    tick();
    check_result("extreme_load", Result, 32'h8000_0000);
    acc_load = 1'b0;
    tick();
    check_result("extreme_16384", Result, 32'd16384);

    // Back to 80, then freeze with en=0 while inputs change
    acc_load = 1'b1; Z = 32'sd50; X = 8'sd10; Y = 8'sd3;
    tick();
    check_result("reload_50", Result, 32'd16384);
    acc_load = 1'b0;
    tick();
    check_result("pre_freeze_80", Result, 32'd80);
    en = 1'b0; acc_load = 1'b1; Z = 32'sd999; X = 8'sd1; Y = 8'sd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_result($sformatf("freeze_%0d", i), Result, 32'd80);
    end
    // Re-enable: base was not loaded while frozen, so first edge still gives 50+30
    en = 1'b1;
    tick();
    check_result("reenable_edge1", Result, 32'd80);
    acc_load = 1'b0;
    tick();
    check_result("reenable_edge2", Result, 32'd1000);

    // Mid-stream reset beats en and acc_load, then rebuild from X=2, Y=3 with no load
    rst = 1'b1; acc_load = 1'b1; Z = 32'sd5;
    tick();
    check_result("midrst_clear", Result, 32'd0);
    rst = 1'b0; acc_load = 1'b0; X = 8'sd2; Y = 8'sd3;
    tick();
    check_result("post_rst_edge1", Result, 32'd0);
    tick();
    check_result("post_rst_6", Result, 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
